accumulator_array: RTL and testbench

Multi-column, parametrised partial-sum accumulator at the south edge of the systolic array. Stores one row of SIZE signed partial sums per address, accumulating incoming column sums or overwriting them, and accepts a second, narrower write port for compensation results. It adds a random-access read port and a drain engine that streams every row out over a valid/ready handshake to the activation/output stage.

---
 rtl/accumulator_pkg.sv | 37 +++
 rtl/acc_lane.sv | 36 +++
 rtl/accumulator_array.sv | 144 ++++++++++++++
 tb/tb_accumulator_array.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_pkg.sv
// Shared constants, drain FSM encoding and lane helpers
// for the south-edge partial-sum accumulator.
package accumulator_pkg;

  localparam int SIZE_DEF  = 8;
  localparam int DEPTH_DEF = 8;
  localparam int PSW_DEF   = 16 + $clog2(SIZE_DEF);
  localparam int CPSW_DEF  = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } drain_state_t;

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] lane_sext(
    input logic [63:0] v,
    input int          w
  );
    logic signed [63:0] t;
    t = $signed(v << (64 - w));
    return 64'(t >>> (64 - w));
  endfunction

  // {overflow, clamp_negative} for a signed add a + b = s.
  function automatic logic [1:0] sat_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    logic ovf;
    ovf = (a_msb == b_msb) && (s_msb != a_msb);
    return {ovf, a_msb};
  endfunction

endpackage

// File: rtl/acc_lane.sv
// Single-lane overwrite / accumulate datapath.
// ACC_SATURATE_EN clamps the accumulate sum on signed overflow.
module acc_lane
  import accumulator_pkg::*;
#(
  parameter int PSW = PSW_DEF
) (
  input  logic [PSW-1:0] cur,
  input  logic [PSW-1:0] psum,
  input  logic           first,
  output logic [PSW-1:0] nxt
);

  logic [PSW-1:0] sum;

  assign sum = cur + psum;

`ifdef ACC_SATURATE_EN
  logic [1:0] sel;

  assign sel = sat_ovf(cur[PSW-1], psum[PSW-1], sum[PSW-1]);

  always_comb begin
    nxt = sum;
    if (first)
      nxt = psum;
    else if (sel[1] && sel[0])
      nxt = {1'b1, {(PSW-1){1'b0}}};
    else if (sel[1])
      nxt = {1'b0, {(PSW-1){1'b1}}};
  end
`else
  assign nxt = first ? psum : sum;
`endif

endmodule

// File: rtl/accumulator_array.sv
// Row-addressed partial-sum accumulator with read port and drain engine.
// Optional: ACC_SATURATE_EN enables saturating accumulation.
module accumulator_array
  import accumulator_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PSW   = 16 + $clog2(SIZE),
  parameter int CPSW  = CPSW_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acc_wr_en,
  input  logic                acc_wr_first,
  input  logic [AW-1:0]       acc_wr_addr,
  input  logic [SIZE*PSW-1:0] psum_in,
  input  logic                cacc_wr_en,
  input  logic [AW-1:0]       cacc_wr_addr,
  input  logic [SIZE*CPSW-1:0] cpsum_in,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [SIZE*PSW-1:0] psum_out,
  output logic                psum_out_valid,
  input  logic                drain_start,
  output logic                drain_busy,
  output logic                drain_valid,
  input  logic                drain_ready,
  output logic [SIZE*PSW-1:0] drain_data,
  output logic [AW-1:0]       drain_addr,
  output logic                drain_last
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [PSW-1:0]      mem     [DEPTH][SIZE];
  logic [PSW-1:0]      acc_nxt [SIZE];
  logic [PSW-1:0]      cmp_val [SIZE];
  logic [SIZE*PSW-1:0] rd_row;
  logic [SIZE*PSW-1:0] dr_row;
  drain_state_t        state;
  drain_state_t        state_nxt;
  logic [AW-1:0]       ptr;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    assign cmp_val[i] = PSW'(lane_sext(
      64'(cpsum_in[i*CPSW +: CPSW]), CPSW));

    acc_lane #(
      .PSW (PSW)
    ) u_lane (
      .cur   (mem[acc_wr_addr][i]),
      .psum  (psum_in[i*PSW +: PSW]),
      .first (acc_wr_first),
      .nxt   (acc_nxt[i])
    );

    assign rd_row[i*PSW +: PSW] = mem[rd_addr][i];
    assign dr_row[i*PSW +: PSW] = mem[ptr][i];
  end

  // Compensation overrides a same-row accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++)
        for (int i = 0; i < SIZE; i++)
          mem[r][i] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++)
        for (int i = 0; i < SIZE; i++)
          if (cacc_wr_en && cacc_wr_addr == AW'(r))
            mem[r][i] <= cmp_val[i];
          else if (acc_wr_en && acc_wr_addr == AW'(r))
            mem[r][i] <= acc_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psum_out       <= '0;
      psum_out_valid <= 1'b0;
    end else begin
      psum_out_valid <= rd_en && !drain_busy;
      if (rd_en && !drain_busy)
        psum_out <= rd_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (drain_start)
          state_nxt = FETCH;
      FETCH:
        state_nxt = HOLD;
      HOLD:
        if (drain_valid && drain_ready)
          state_nxt = (ptr == LAST) ? IDLE : FETCH;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      drain_data  <= '0;
      drain_addr  <= '0;
      drain_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (drain_start)
            ptr <= '0;
        FETCH: begin
          drain_data  <= dr_row;
          drain_addr  <= ptr;
          drain_valid <= 1'b1;
        end
        HOLD:
          if (drain_valid && drain_ready) begin
            drain_valid <= 1'b0;
            if (ptr != LAST)
              ptr <= ptr + AW'(1);
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    drain_busy = (state != IDLE);
    drain_last = drain_valid && (drain_addr == LAST);
  end

endmodule

// File: tb/tb_accumulator_array.sv
// Randomized scoreboard bench for accumulator_array against
// an arithmetic row/lane model of the accumulator memory.
module tb_accumulator_array;

  localparam int SIZE  = 8;
  localparam int DEPTH = 8;
  localparam int PSW   = 19;
  localparam int CPSW  = 14;
  localparam int AW    = 3;
  localparam int RW    = SIZE * PSW;
  localparam longint MAXV = (longint'(1) <<< (PSW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (PSW-1));

  typedef logic [RW-1:0]        row_t;
  typedef logic [SIZE*CPSW-1:0] crow_t;
  typedef struct {
    row_t d;
    int   a;
    bit   l;
  } dx_t;

  logic          clk = 0;
  logic          rst = 1;
  logic          acc_wr_en = 0;
  logic          acc_wr_first = 0;
  logic [AW-1:0] acc_wr_addr = 0;
  row_t          psum_in = 0;
  logic          cacc_wr_en = 0;
  logic [AW-1:0] cacc_wr_addr = 0;
  crow_t         cpsum_in = 0;
  logic          rd_en = 0;
  logic [AW-1:0] rd_addr = 0;
  row_t          psum_out;
  logic          psum_out_valid;
  logic          drain_start = 0;
  logic          drain_busy;
  logic          drain_valid;
  logic          drain_ready = 0;
  row_t          drain_data;
  logic [AW-1:0] drain_addr;
  logic          drain_last;

  int     checks = 0;
  int     errors = 0;
  longint mdl [DEPTH][SIZE];
  row_t   rd_q [$];
  dx_t    dq [$];

  accumulator_array #(
    .SIZE (SIZE), .DEPTH (DEPTH), .PSW (PSW),
    .CPSW (CPSW), .AW (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .acc_wr_en      (acc_wr_en),
    .acc_wr_first   (acc_wr_first),
    .acc_wr_addr    (acc_wr_addr),
    .psum_in        (psum_in),
    .cacc_wr_en     (cacc_wr_en),
    .cacc_wr_addr   (cacc_wr_addr),
    .cpsum_in       (cpsum_in),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .psum_out       (psum_out),
    .psum_out_valid (psum_out_valid),
    .drain_start    (drain_start),
    .drain_busy     (drain_busy),
    .drain_valid    (drain_valid),
    .drain_ready    (drain_ready),
    .drain_data     (drain_data),
    .drain_addr     (drain_addr),
    .drain_last     (drain_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint fold(longint s);
`ifdef ACC_SATURATE_EN
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
`else
    longint m;
    m = longint'(1) <<< PSW;
    s = s % m;
    if (s < 0) s += m;
    if (s > MAXV) s -= m;
    return s;
`endif
  endfunction

  function automatic row_t pack_row(int r);
    row_t v;
    for (int i = 0; i < SIZE; i++) v[i*PSW +: PSW] = mdl[r][i][PSW-1:0];
    return v;
  endfunction

  function automatic row_t fill(longint x);
    row_t v;
    for (int i = 0; i < SIZE; i++) v[i*PSW +: PSW] = x[PSW-1:0];
    return v;
  endfunction

  function automatic crow_t cfill(longint x);
    crow_t v;
    for (int i = 0; i < SIZE; i++) v[i*CPSW +: CPSW] = x[CPSW-1:0];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < DEPTH; r++)
      for (int i = 0; i < SIZE; i++) mdl[r][i] = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit aw, input bit af, input int aa,
                       input row_t pin, input bit cw, input int ca,
                       input crow_t cin, input bit rd, input int ra);
    if (rd) rd_q.push_back(pack_row(ra));
    for (int i = 0; i < SIZE; i++) begin
      longint p;
      p = longint'($signed(pin[i*PSW +: PSW]));
      if (aw) mdl[aa][i] = af ? p : fold(mdl[aa][i] + p);
      if (cw) mdl[ca][i] = longint'($signed(cin[i*CPSW +: CPSW]));
    end
    acc_wr_en = aw; acc_wr_first = af;
    acc_wr_addr = AW'(aa); psum_in = pin;
    cacc_wr_en = cw; cacc_wr_addr = AW'(ca); cpsum_in = cin;
    rd_en = rd; rd_addr = AW'(ra);
    cyc();
    acc_wr_en = 0; cacc_wr_en = 0; rd_en = 0;
  endtask

  task automatic acc_w(input int a, input bit first, input row_t v);
    drive(1, first, a, v, 0, 0, '0, 0, 0);
  endtask

  task automatic read(input int a);
    drive(0, 0, 0, '0, 0, 0, '0, 1, a);
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
    clear_model();
    rd_q.delete();
    dq.delete();
  endtask

  task automatic push_drain();
    for (int r = 0; r < DEPTH; r++) begin
      dx_t e;
      e.d = pack_row(r); e.a = r; e.l = (r == DEPTH-1);
      dq.push_back(e);
    end
  endtask

  task automatic run_drain(input int mode, input bit rd_dur,
                           output int n);
    int pulses;
    pulses = 0;
    push_drain();
    drain_start = 1;
    cyc();
    drain_start = 0;
    rd_en = rd_dur;
    rd_addr = AW'($urandom_range(DEPTH-1));
    n = 0;
    while (drain_busy && n < 400) begin
      unique case (mode)
        0: drain_ready = 1;
        1: drain_ready = (n % 3 != 1);
        default: drain_ready = 1'($urandom);
      endcase
      cyc();
      n++;
      pulses += int'(psum_out_valid);
    end
    rd_en = 0;
    drain_ready = 0;
    chk("drain_done", row_t'(drain_busy), 0);
    chk("drain_q_empty", row_t'(dq.size()), 0);
    if (rd_dur) chk("rd_ignored", row_t'(pulses), 0);
  endtask

  task automatic random_ops(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      row_t  pin;
      crow_t cin;
      for (int i = 0; i < SIZE; i++) begin
        pin[i*PSW +: PSW]   = PSW'($urandom);
        cin[i*CPSW +: CPSW] = CPSW'($urandom);
      end
      drive(1'($urandom), ($urandom_range(3) == 0),
            $urandom_range(DEPTH-1), pin,
            ($urandom_range(4) == 0), $urandom_range(DEPTH-1), cin,
            ($urandom_range(2) == 0), $urandom_range(DEPTH-1));
    end
  endtask

  initial begin : monitor
    row_t hd;
    int   ha;
    bit   hv;
    hv = 0;
    hd = '0;
    ha = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = 0;
      end else begin
        if (hv) begin
          chk("stall_valid", row_t'(drain_valid), 1);
          chk("stall_data", drain_data, hd);
          chk("stall_addr", row_t'(drain_addr), row_t'(ha));
        end
        if (drain_valid && drain_ready) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL drain_extra: got row %0d expected none",
                     drain_addr);
          end else begin
            dx_t e;
            e = dq.pop_front();
            chk("drain_data", drain_data, e.d);
            chk("drain_addr", row_t'(drain_addr), row_t'(e.a));
            chk("drain_last", row_t'(drain_last), row_t'(e.l));
          end
        end
        hv = drain_valid && !drain_ready;
        hd = drain_data;
        ha = int'(drain_addr);
        if (psum_out_valid) begin
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_extra: got %0h expected no read", psum_out);
          end else begin
            chk("rd_data", psum_out, rd_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    clear_model();
    cyc();
    cyc();
    rst = 0;
    chk("rst_psum_out", psum_out, 0);
    chk("rst_out_valid", row_t'(psum_out_valid), 0);
    chk("rst_drain_valid", row_t'(drain_valid), 0);
    chk("rst_drain_busy", row_t'(drain_busy), 0);
    chk("rst_drain_data", drain_data, 0);
    chk("rst_drain_addr", row_t'(drain_addr), 0);

    acc_w(3, 1, fill(5));
    repeat (3) acc_w(3, 0, fill(7));
    read(3);
    chk("t1_valid", row_t'(psum_out_valid), 1);
    chk("t1_lane5", row_t'(psum_out[5*PSW +: PSW]), 26);
    cyc();
    chk("t1_pulse", row_t'(psum_out_valid), 0);

    drive(1, 0, 2, fill(10), 1, 2, cfill(-3), 0, 0);
    read(2);
    chk("t2_sext", row_t'(psum_out[PSW-1:0]), 19'h7FFFD);

    acc_w(1, 1, fill(MAXV - 1));
    acc_w(1, 0, fill(5));
    read(1);
`ifdef ACC_SATURATE_EN
    chk("t3_sat", row_t'(psum_out[PSW-1:0]), 19'h3FFFF);
`else
    chk("t3_wrap", row_t'(psum_out[PSW-1:0]), 19'h40003);
`endif

    acc_w(4, 1, fill(1));
    drive(1, 1, 4, fill(9), 0, 0, '0, 1, 4);
    chk("t4_rbw", row_t'(psum_out[PSW-1:0]), 1);
    read(4);
    chk("t4_new", row_t'(psum_out[PSW-1:0]), 9);

    for (int r = 0; r < DEPTH; r++) acc_w(r, 1, fill(r));
    run_drain(1, 0, n);
    run_drain(0, 1, n);
    chk("drain_cycles", row_t'(n), row_t'(2*DEPTH));

    random_ops(300);
    run_drain(2, 0, n);
    random_ops(200);
    cyc();

    push_drain();
    drain_start = 1;
    cyc();
    drain_start = 0;
    drain_ready = 1;
    n = 0;
    while (!(drain_valid && drain_addr == 3) && n < 100) begin
      cyc();
      n++;
    end
    chk("mid_reach_row3", row_t'(drain_addr == 3 && drain_valid), 1);
    do_reset();
    drain_ready = 0;
    chk("mid_valid", row_t'(drain_valid), 0);
    chk("mid_busy", row_t'(drain_busy), 0);
    for (int r = 0; r < DEPTH; r++) read(r);
    repeat (3) cyc();
    chk("rd_q_empty", row_t'(rd_q.size()), 0);
    chk("dq_empty", row_t'(dq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
